// File: rtl/sqrt_pkg.sv
// sqrt_pkg: state encoding and sizing helper shared by the sqrt_seq files.
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int calc_n(input int width, input int bpc);
    return (width / 2) / bpc;
  endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one restoring digit-by-digit square-root iteration (combinational).
module sqrt_step #(
  parameter int HW = 8
) (
  input  logic [HW+1:0] rem_in,
  input  logic [HW-1:0] root_in,
  input  logic [1:0]    xb,
  output logic [HW+1:0] rem_out,
  output logic [HW-1:0] root_out
);
  logic [HW+3:0] rem_t;
  logic [HW+1:0] trial;
  logic          ge;
  assign rem_t    = {rem_in, xb};
  assign trial    = {root_in, 2'b01};
  assign ge       = rem_t >= {2'b00, trial};
  assign rem_out  = ge ? rem_t[HW+1:0] - trial : rem_t[HW+1:0];
  assign root_out = {root_in[HW-2:0], ge};
endmodule

// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential floor square root with remainder, valid/ready on both sides.
// Define SQRT_ROUND_EN to round the root to nearest (remainder stays the floor one).
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);
  localparam int HW = WIDTH / 2;
  localparam int N  = calc_n(WIDTH, BITS_PER_CYCLE);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t          state, state_nx;
  logic [WIDTH-1:0] x_sh;
  logic [HW+1:0]   rem_r;
  logic [HW-1:0]   root_r, root_fin;
  logic [CW-1:0]   cnt;
  logic [HW+1:0]   rem_ch  [BITS_PER_CYCLE+1];
  logic [HW-1:0]   root_ch [BITS_PER_CYCLE+1];
  if ((WIDTH % 2) != 0 || WIDTH < 4 || ((WIDTH / 2) % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("sqrt_seq: WIDTH must be even and >= 4, BITS_PER_CYCLE must divide WIDTH/2");
  end
  assign rem_ch[0]  = rem_r;
  assign root_ch[0] = root_r;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    sqrt_step #(.HW(HW)) u_step (
      .rem_in  (rem_ch[i]),
      .root_in (root_ch[i]),
      .xb      (x_sh[WIDTH-1-2*i -: 2]),
      .rem_out (rem_ch[i+1]),
      .root_out(root_ch[i+1])
    );
  end
`ifdef SQRT_ROUND_EN
  // round up when the floor remainder exceeds the floor root, saturating at all-ones
  assign root_fin = (rem_ch[BITS_PER_CYCLE] > {2'b00, root_ch[BITS_PER_CYCLE]} && !(&root_ch[BITS_PER_CYCLE]))
                  ? root_ch[BITS_PER_CYCLE] + HW'(1) : root_ch[BITS_PER_CYCLE];
`else
  assign root_fin = root_ch[BITS_PER_CYCLE];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? CALC : IDLE)
             : state == CALC ? (cnt == '0 ? DONE : CALC)
             : state == DONE ? (out_ready ? IDLE : DONE)
             : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_sh   <= '0;
      rem_r  <= '0;
      root_r <= '0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      x_sh   <= x;
      rem_r  <= '0;
      root_r <= '0;
      cnt    <= CW'(N - 1);
    end else if (state == CALC) begin
      x_sh   <= x_sh << (2 * BITS_PER_CYCLE);
      rem_r  <= rem_ch[BITS_PER_CYCLE];
      root_r <= cnt == '0 ? root_fin : root_ch[BITS_PER_CYCLE];
      cnt    <= cnt == '0 ? cnt : cnt - CW'(1);
    end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign root      = root_r;
  assign rem       = rem_r[HW:0];
endmodule
